uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART TX datapath (FSM + serializer + parity + mux) between NUM_REQ byte requesters.
- Selects requesters round-robin and latches the winner's byte and parity-enable.
- Presents the frame to the UART TX as a one-cycle Data_Valid pulse, then tracks the TX busy flag until the frame has gone out.
- Sits between the application-side producers and the UART_TX top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame payload width
START_TO, 4, max cycles after issue to wait for tx_busy rising before abort
GAP_CYCLES, 2, idle cycles between frames (used only with UART_TX_GAP_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester frame request, held until req_ack
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_par_en  in  NUM_REQ  per-requester parity enable
req_ack  out  NUM_REQ  one-hot, one-cycle pulse: frame captured
tx_busy  in  1  busy from UART TX
tx_data  out  DATA_WIDTH  P_DATA to UART TX
tx_data_valid  out  1  Data_Valid to UART TX, one-cycle pulse
tx_par_en  out  1  PAR_EN to UART TX, stable for the whole frame
grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester
arb_busy  out  1  high in every state except IDLE
tx_err  out  1  one-cycle pulse on start timeout

Behaviour:
- Reset (rst low, async): state=IDLE. All outputs are 0. RR pointer=0 (requester 0 highest). Start and gap counters are 0. Any frame in flight is dropped with no ack.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP (GAP exists only with the macro).
- IDLE:
  - If any req_valid is set and tx_busy=0: winner = first set bit scanning from pointer upward, wrapping mod NUM_REQ.
  - Latch winner's data to tx_data, its par_en to tx_par_en, its index to grant_id. Go to ISSUE.
  - If tx_busy=1: stay in IDLE, no grant.
- ISSUE (1 cycle):
  - tx_data_valid=1 and req_ack[grant_id]=1.
  - pointer <= (grant_id+1) mod NUM_REQ.
  - Go to WAIT_START; clear the start counter.
- WAIT_START:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TO without busy, pulse tx_err for 1 cycle and go to IDLE. The frame is lost and the ack has already been given.
- WAIT_DONE:
  - Stay while tx_busy=1.
  - tx_busy=0 -> IDLE, or GAP when the macro is defined.
- Latency: request registered in IDLE at edge k -> tx_data_valid and req_ack high in cycle k+1.
- Best case is one frame per (frame length + 3) cycles.
- tx_data and tx_par_en hold their values from the grant until the next grant.
- Protocol: requesters keep req_valid and data stable until ack. A requester may present new data in the cycle after ack. A req_valid that drops before ack is simply not granted. A captured frame is always issued.
- Simultaneous events:
  - req_valid rising in the same cycle tx_busy falls in WAIT_DONE: no grant that cycle; the grant happens in the next IDLE cycle.
  - A new req_valid arriving during a frame waits for IDLE.
- NUM_REQ not a power of two: pointer wrap uses an explicit compare, not bit truncation.

Optional Feature:
Macro UART_TX_GAP_EN.
- Defined:
  - WAIT_DONE exits to GAP, which holds for exactly GAP_CYCLES cycles with arb_busy=1 and then goes to IDLE.
  - GAP_CYCLES=0 behaves as not defined.
- Not defined: no GAP state; WAIT_DONE -> IDLE directly.

Test Plan:
- Single request: req_valid=4'b0001, data 8'hA5, par_en=1, model TX raises busy 1 cycle after Data_Valid and holds it 11 cycles -> one Data_Valid pulse with tx_data=A5, tx_par_en=1, req_ack=0001 for one cycle, arb_busy back to 0 one cycle after busy falls.
- All four requesters held valid from reset release -> grants in order 0,1,2,3. Each req_ack is pulsed once. No Data_Valid is issued while tx_busy=1.
- Fairness: after a grant to 2, assert requesters 1 and 3 -> grant 3 first, then 1, with grant_id 3 then 1.
- tx_busy held high in IDLE with req_valid=0001 -> no ack and no Data_Valid until busy drops; the grant follows the next cycle.
- Start timeout: TX model never raises busy -> tx_err pulses exactly START_TO cycles after WAIT_START entry and the FSM returns to IDLE. The next request is served normally.
- Reset mid-frame: rst low during WAIT_DONE -> all outputs 0 immediately (async). After release, the pointer restarts at requester 0. With UART_TX_GAP_EN and GAP_CYCLES=2, there are exactly 2 idle cycles between busy falling and the next Data_Valid setup.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters, the arbiter and the UART TX.
// master: arbiter side (drives TX + acks); slave: requesters/TX side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_par_en;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          tx_busy;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_data_valid;
  logic                          tx_par_en;
  logic [IDW-1:0]                grant_id;
  logic                          arb_busy;
  logic                          tx_err;

  modport master (
    input  req_valid, req_data, req_par_en, tx_busy,
    output req_ack, tx_data, tx_data_valid, tx_par_en,
    output grant_id, arb_busy, tx_err
  );

  modport slave (
    output req_valid, req_data, req_par_en, tx_busy,
    input  req_ack, tx_data, tx_data_valid, tx_par_en,
    input  grant_id, arb_busy, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NUM_REQ requesters.
// Ports: clk, rst (async active-low), bus (uart_tx_arbiter_if.master).
// Optional: define UART_TX_GAP_EN to insert GAP_CYCLES idle cycles
// between frames (GAP_CYCLES=0 behaves as undefined).
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int START_TO   = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(START_TO + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 2);
`ifdef UART_TX_GAP_EN
  localparam bit GapMacro = 1'b1;
`else
  localparam bit GapMacro = 1'b0;
`endif
  localparam bit GapEn = GapMacro && (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d;
  logic [CW-1:0]         scnt_q, scnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic                  err_q, err_d;

  logic [IDW-1:0]        win;
  logic                  found;
  int                    idx;

  // Scan from the pointer upward; wrap by compare so
  // non-power-of-two NUM_REQ never aliases.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    par_d   = par_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !bus.tx_busy) begin
          state_d = ISSUE;
          gid_d   = win;
          data_d  = bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          par_d   = bus.req_par_en[win];
        end
      end
      ISSUE: begin
        ptr_d   = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        scnt_d  = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (scnt_q == CW'(START_TO - 1)) begin
          // Frame lost; the ack was already given in ISSUE.
          scnt_d  = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (GapEn) begin
            gcnt_d  = '0;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          gcnt_d  = '0;
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      par_q   <= par_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.tx_data_valid = (state_q == ISSUE);
  assign bus.req_ack       = (state_q == ISSUE)
                           ? (NUM_REQ'(1) << gid_q) : '0;
  assign bus.tx_data       = data_q;
  assign bus.tx_par_en     = par_q;
  assign bus.grant_id      = gid_q;
  assign bus.arb_busy      = (state_q != IDLE);
  assign bus.tx_err        = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART TX busy model.
// Ports: none (top-level bench).
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int STO = 4;
`ifdef UART_TX_GAP_EN
  localparam int GAPX = 2;
`else
  localparam int GAPX = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .START_TO(STO), .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit model_en  = 1'b0;
  int busy_left = 0;
  bit dv_seen   = 1'b0;

  // TX model: busy rises one cycle after Data_Valid, held 11 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (model_en) begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.tx_busy = 1'b0;
        end else if (dv_seen) begin
          bus.tx_busy = 1'b1;
          busy_left   = 11;
        end
        dv_seen = bus.tx_data_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    model_en       = 1'b0;
    busy_left      = 0;
    dv_seen        = 1'b0;
    bus.tx_busy    = 1'b0;
    bus.req_valid  = '0;
    bus.req_par_en = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (!bus.arb_busy) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL wait_idle: arb_busy=%b want 0", bus.arb_busy);
    end
  endtask

  task automatic test_reset();
    logic [DW+N+3+2:0] outs;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    step();
    outs = {bus.tx_data_valid, bus.req_ack, bus.tx_data,
            bus.tx_par_en, bus.grant_id, bus.arb_busy, bus.tx_err};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.arb_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: arb_busy=%b want 0", bus.arb_busy);
    end
  endtask

  task automatic test_single();
    int cyc;
    int extra;
    do_reset();
    model_en       = 1'b1;
    bus.req_data   = {8'h44, 8'h33, 8'h22, 8'hA5};
    bus.req_par_en = 4'b0001;
    bus.req_valid  = 4'b0001;
    step();
    n_cmp++;
    if ({bus.tx_data_valid, bus.req_ack, bus.tx_data,
         bus.tx_par_en, bus.grant_id}
        !== {1'b1, 4'b0001, 8'hA5, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL single_issue: dv=%b ack=%b d=%h p=%b g=%0d want 1 0001 a5 1 0",
               bus.tx_data_valid, bus.req_ack, bus.tx_data,
               bus.tx_par_en, bus.grant_id);
    end
    bus.req_valid = '0;
    cyc   = 0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cyc++;
      if (bus.tx_data_valid || bus.req_ack != '0) extra++;
      if (!bus.arb_busy) break;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++;
      $display("FAIL single_extra: pulses=%0d want 0", extra);
    end
    n_cmp++;
    if (cyc !== 13 + GAPX) begin
      n_bad++;
      $display("FAIL single_len: idle after %0d want %0d",
               cyc, 13 + GAPX);
    end
    n_cmp++;
    if (bus.tx_data !== 8'hA5 || bus.tx_par_en !== 1'b1) begin
      n_bad++;
      $display("FAIL single_hold: d=%h p=%b want a5 1",
               bus.tx_data, bus.tx_par_en);
    end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_d [4];
    logic       exp_p [4];
    int acks [4];
    int g;
    int t;
    int last;
    int bad_busy;
    exp_d = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    exp_p = '{1'b0, 1'b1, 1'b0, 1'b1};
    acks  = '{0, 0, 0, 0};
    do_reset();
    model_en       = 1'b1;
    bus.req_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.req_par_en = 4'b1010;
    bus.req_valid  = 4'b1111;
    g = 0; t = 0; last = 0; bad_busy = 0;
    for (int i = 0; i < 120 && g < 4; i++) begin
      step();
      t++;
      for (int r = 0; r < 4; r++) acks[r] += int'(bus.req_ack[r]);
      if (bus.tx_data_valid) begin
        if (bus.tx_busy) bad_busy++;
        n_cmp++;
        if (bus.grant_id !== 2'(g) || bus.tx_data !== exp_d[g]
            || bus.tx_par_en !== exp_p[g]) begin
          n_bad++;
          $display("FAIL rr_grant%0d: g=%0d d=%h p=%b want %0d %h %b",
                   g, bus.grant_id, bus.tx_data, bus.tx_par_en,
                   g, exp_d[g], exp_p[g]);
        end
        if (g > 0) begin
          n_cmp++;
          if (t - last !== 14 + GAPX) begin
            n_bad++;
            $display("FAIL rr_spacing%0d: %0d cycles want %0d",
                     g, t - last, 14 + GAPX);
          end
        end
        last = t;
        bus.req_valid[bus.grant_id] = 1'b0;
        g++;
      end
    end
    n_cmp++;
    if (g !== 4) begin
      n_bad++;
      $display("FAIL rr_count: grants=%0d want 4", g);
    end
    wait_idle();
    n_cmp++;
    if (acks != '{1, 1, 1, 1}) begin
      n_bad++;
      $display("FAIL rr_acks: %0d %0d %0d %0d want 1 1 1 1",
               acks[0], acks[1], acks[2], acks[3]);
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL rr_dv_busy: %0d issues while busy want 0",
               bad_busy);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [2];
    int g;
    exp_g = '{2'd3, 2'd1};
    do_reset();
    model_en      = 1'b1;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b0100;
    step();
    n_cmp++;
    if (bus.tx_data_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
      n_bad++;
      $display("FAIL fair_first: dv=%b g=%0d want 1 2",
               bus.tx_data_valid, bus.grant_id);
    end
    bus.req_valid = 4'b1010;
    g = 0;
    for (int i = 0; i < 80 && g < 2; i++) begin
      step();
      if (bus.tx_data_valid) begin
        n_cmp++;
        if (bus.grant_id !== exp_g[g]) begin
          n_bad++;
          $display("FAIL fair_order%0d: g=%0d want %0d",
                   g, bus.grant_id, exp_g[g]);
        end
        bus.req_valid[bus.grant_id] = 1'b0;
        g++;
      end
    end
    n_cmp++;
    if (g !== 2) begin
      n_bad++;
      $display("FAIL fair_count: grants=%0d want 2", g);
    end
    wait_idle();
  endtask

  task automatic test_busy_idle();
    int seen;
    do_reset();
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h3C};
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b0001;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.tx_data_valid || bus.req_ack != '0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL busy_hold: %0d grants want 0", seen);
    end
    bus.tx_busy = 1'b0;
    dv_seen     = 1'b0;
    model_en    = 1'b1;
    step();
    n_cmp++;
    if ({bus.tx_data_valid, bus.req_ack, bus.tx_data}
        !== {1'b1, 4'b0001, 8'h3C}) begin
      n_bad++;
      $display("FAIL busy_release: dv=%b ack=%b d=%h want 1 0001 3c",
               bus.tx_data_valid, bus.req_ack, bus.tx_data);
    end
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_timeout();
    logic [5:0] errs;
    logic       busy5;
    do_reset();
    bus.req_data  = {8'h00, 8'h00, 8'h5C, 8'h77};
    bus.req_valid = 4'b0001;
    step();
    n_cmp++;
    if (bus.tx_data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL to_issue: dv=%b want 1", bus.tx_data_valid);
    end
    bus.req_valid = '0;
    errs  = '0;
    busy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      errs[i] = bus.tx_err;
      if (i == 4) busy5 = bus.arb_busy;
    end
    n_cmp++;
    if (errs !== 6'b010000) begin
      n_bad++;
      $display("FAIL to_err: pattern=%b want 010000", errs);
    end
    n_cmp++;
    if (busy5 !== 1'b0) begin
      n_bad++;
      $display("FAIL to_idle: arb_busy=%b want 0", busy5);
    end
    dv_seen       = 1'b0;
    model_en      = 1'b1;
    bus.req_valid = 4'b0010;
    step();
    n_cmp++;
    if ({bus.tx_data_valid, bus.grant_id, bus.tx_data}
        !== {1'b1, 2'd1, 8'h5C}) begin
      n_bad++;
      $display("FAIL to_next: dv=%b g=%0d d=%h want 1 1 5c",
               bus.tx_data_valid, bus.grant_id, bus.tx_data);
    end
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW+N+3+2:0] outs;
    do_reset();
    model_en       = 1'b1;
    bus.req_data   = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
    bus.req_par_en = 4'b0100;
    bus.req_valid  = 4'b0100;
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({bus.arb_busy, bus.tx_busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_frame: arb_busy=%b tx_busy=%b want 1 1",
               bus.arb_busy, bus.tx_busy);
    end
    #2;
    rst         = 1'b0;
    model_en    = 1'b0;
    busy_left   = 0;
    dv_seen     = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    outs = {bus.tx_data_valid, bus.req_ack, bus.tx_data,
            bus.tx_par_en, bus.grant_id, bus.arb_busy, bus.tx_err};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL mid_async: outs=%h want 0", outs);
    end
    step();
    rst           = 1'b1;
    model_en      = 1'b1;
    bus.req_valid = 4'b1010;
    step();
    n_cmp++;
    if ({bus.tx_data_valid, bus.grant_id} !== {1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL mid_ptr: dv=%b g=%0d want 1 1",
               bus.tx_data_valid, bus.grant_id);
    end
    bus.req_valid = '0;
    wait_idle();
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_par_en = '0;
    bus.tx_busy    = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_busy_idle();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want test end");
    $fatal(1, "watchdog");
  end
endmodule
